aes_dec_round_ctrl: RTL and testbench

Round sequencer for the AES-128 decrypt datapath. Accepts one ciphertext block and runs the inverse cipher: initial AddRoundKey, then nine rounds of front-end, AddRoundKey and InvMixColumns, then a final front-end and AddRoundKey. The front-end is an external combinational InvShiftRows+InvSubBytes. InvMixColumns is external, takes MIX_LAT cycles and is driven from StateOut. The block owns the state register, round counter, round-key index and AddRoundKey XOR.

---
 rtl/aes_dec_round_ctrl_if.sv | 28 ++
 rtl/aes_dec_round_ctrl.sv | 110 +++++++++++
 tb/tb_aes_dec_round_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_round_ctrl_if.sv
// Handshake and datapath bundle between the AES-128 decrypt round sequencer and its
// surroundings (key store, InvShiftRows/InvSubBytes front-end, InvMixColumns, producer, consumer).
interface aes_dec_round_ctrl_if;
  logic         InValid;
  logic         InReady;
  logic [127:0] InData;
  logic [3:0]   RkIdx;
  logic [127:0] RkData;
  logic [127:0] StateOut;
  logic [127:0] FeIn;
  logic [127:0] MixIn;
  logic         OutValid;
  logic         OutReady;
  logic [127:0] OutData;
  logic         Busy;

  // Environment side: producer, consumer, key store and the external round functions.
  modport master (
    output InValid, InData, RkData, FeIn, MixIn, OutReady,
    input  InReady, RkIdx, StateOut, OutValid, OutData, Busy
  );

  // Sequencer side.
  modport slave (
    input  InValid, InData, RkData, FeIn, MixIn, OutReady,
    output InReady, RkIdx, StateOut, OutValid, OutData, Busy
  );
endinterface

// File: rtl/aes_dec_round_ctrl.sv
// AES-128 inverse-cipher round sequencer: owns state register, round counter, key index and
// AddRoundKey. Optional macro AES_DEC_ABORT_EN adds an Abort input that returns the FSM to idle.
module aes_dec_round_ctrl #(
  parameter int unsigned MIX_LAT = 3,
  parameter int unsigned NR      = 10
) (
  input logic                 Clk,
  input logic                 RstN,
`ifdef AES_DEC_ABORT_EN
  input logic                 Abort,
`endif
  aes_dec_round_ctrl_if.slave bus
);

  localparam int unsigned     WaitW    = $clog2(MIX_LAT + 1);
  localparam logic [3:0]      NrIdx    = 4'(NR);
  localparam logic [WaitW-1:0] LastWait = WaitW'(MIX_LAT - 1);

  typedef enum logic [1:0] {StIdle, StFront, StMix, StDone} state_e;

  state_e           fsm_q;
  logic [127:0]     state_q;
  logic [3:0]       round_q;
  logic [3:0]       rk_idx_q;
  logic [WaitW-1:0] wait_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             abort_req;

`ifdef AES_DEC_ABORT_EN
  assign abort_req = Abort;
`else
  assign abort_req = 1'b0;
`endif

  // Handshake flags and the key index are registered alongside the state transition.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      round_q     <= '0;
      wait_q      <= '0;
      rk_idx_q    <= NrIdx;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort_req && (fsm_q != StIdle)) begin
      // State is deliberately left as-is; only control is cleared.
      fsm_q       <= StIdle;
      round_q     <= '0;
      wait_q      <= '0;
      rk_idx_q    <= NrIdx;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.InValid) begin
            state_q    <= bus.InData ^ bus.RkData;
            round_q    <= NrIdx - 4'd1;
            rk_idx_q   <= NrIdx - 4'd1;
            fsm_q      <= StFront;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StFront: begin
          state_q <= bus.FeIn ^ bus.RkData;
          if (round_q == 4'd0) begin
            fsm_q       <= StDone;
            rk_idx_q    <= 4'd0;
            out_valid_q <= 1'b1;
          end else begin
            fsm_q  <= StMix;
            wait_q <= '0;
          end
        end
        StMix: begin
          wait_q <= wait_q + 1'b1;
          if (wait_q == LastWait) begin
            state_q  <= bus.MixIn;
            round_q  <= round_q - 4'd1;
            rk_idx_q <= round_q - 4'd1;
            fsm_q    <= StFront;
          end
        end
        StDone: begin
          if (bus.OutReady) begin
            fsm_q       <= StIdle;
            rk_idx_q    <= NrIdx;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = out_valid_q;
  assign bus.Busy     = busy_q;
  assign bus.RkIdx    = rk_idx_q;
  assign bus.StateOut = state_q;
  assign bus.OutData  = state_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: behavioural key store, inverse front-end and InvMixColumns with
// a stability-gated latency model; two instances cover MIX_LAT=3 and MIX_LAT=1.
module tb_aes_dec_round_ctrl;

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ZCt   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [43:0]  RkTrace = 44'ha9876543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   iv;
  logic [1:0]   ordy;
  logic [127:0] idat;
  logic [127:0] rk [11];
  int           n_vec = 0;
  int           n_bad = 0;
  int           oob = 0;
  int           age3 = 0;
  int           age1 = 0;
  logic [127:0] last3, last1;

  always #5 clk = ~clk;

  aes_dec_round_ctrl_if bus3 ();
  aes_dec_round_ctrl_if bus1 ();

`ifdef AES_DEC_ABORT_EN
  logic [1:0] ab;
`endif

  aes_dec_round_ctrl #(.MIX_LAT(3), .NR(10)) u_dut3 (
    .Clk  (clk),
    .RstN (rst_n),
`ifdef AES_DEC_ABORT_EN
    .Abort(ab[0]),
`endif
    .bus  (bus3)
  );

  aes_dec_round_ctrl #(.MIX_LAT(1), .NR(10)) u_dut1 (
    .Clk  (clk),
    .RstN (rst_n),
`ifdef AES_DEC_ABORT_EN
    .Abort(ab[1]),
`endif
    .bus  (bus1)
  );

  // ---------------- GF(2^8) and AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, x;
    r = 8'h01;
    x = a;
    for (int i = 1; i < 8; i++) begin
      x = gm(x, x);
      r = gm(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_front(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
      o[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
      o[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
      o[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
    end
    return o;
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- environment models ----------------
  assign bus3.RkData = (bus3.RkIdx <= 4'd10) ? rk[bus3.RkIdx] : '0;
  assign bus1.RkData = (bus1.RkIdx <= 4'd10) ? rk[bus1.RkIdx] : '0;
  assign bus3.FeIn   = inv_front(bus3.StateOut);
  assign bus1.FeIn   = inv_front(bus1.StateOut);
  // MixIn is only correct once StateOut has been stable for MIX_LAT full cycles.
  assign bus3.MixIn  = (age3 >= 3) ? inv_mix(bus3.StateOut) : ~inv_mix(bus3.StateOut);
  assign bus1.MixIn  = (age1 >= 1) ? inv_mix(bus1.StateOut) : ~inv_mix(bus1.StateOut);

  always @(negedge clk) begin
    if (bus3.StateOut !== last3) begin
      last3 <= bus3.StateOut;
      age3  <= 1;
    end else begin
      age3 <= age3 + 1;
    end
    if (bus1.StateOut !== last1) begin
      last1 <= bus1.StateOut;
      age1  <= 1;
    end else begin
      age1 <= age1 + 1;
    end
    if (rst_n && (bus3.RkIdx > 4'd10 || bus1.RkIdx > 4'd10)) oob <= oob + 1;
  end

  assign bus3.InValid  = iv[0];
  assign bus1.InValid  = iv[1];
  assign bus3.InData   = idat;
  assign bus1.InData   = idat;
  assign bus3.OutReady = ordy[0];
  assign bus1.OutReady = ordy[1];

  wire [1:0]   ov  = {bus1.OutValid, bus3.OutValid};
  wire [1:0]   ir  = {bus1.InReady, bus3.InReady};
  wire [1:0]   bsy = {bus1.Busy, bus3.Busy};
  wire [127:0] od0 = bus3.OutData;
  wire [127:0] od1 = bus1.OutData;
  wire [3:0]   rk0 = bus3.RkIdx;
  wire [3:0]   rk1 = bus1.RkIdx;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; counts edges until OutValid and logs RkIdx changes.
  task automatic wait_out(input int s, output int lat, output logic [43:0] trace,
                          output int n);
    logic [3:0] last, cur;
    trace = '0;
    trace[43 -: 4] = 4'd10;
    last = 4'd10;
    n = 1;
    lat = 0;
    while (!ov[s] && lat < 200) begin
      cur = (s == 1) ? rk1 : rk0;
      if (cur != last) begin
        last = cur;
        if (n < 11) trace[43-4*n -: 4] = cur;
        n++;
      end
      wait_edge();
      lat++;
    end
  endtask

  task automatic run_block(input int s, input logic [127:0] ct, output logic [127:0] pt,
                           output int lat, output logic [43:0] trace, output int n);
    idat = ct;
    iv[s] = 1'b1;
    wait_edge();
    iv[s] = 1'b0;
    wait_out(s, lat, trace, n);
    pt = (s == 1) ? od1 : od0;
  endtask

  task automatic finish_block(input int s, input string name);
    ordy[s] = 1'b1;
    wait_edge();
    ordy[s] = 1'b0;
    chk({name, "_ov_after_hs"}, 128'(ov[s]), 128'd0);
    chk({name, "_ir_after_hs"}, 128'(ir[s]), 128'd1);
  endtask

  typedef struct {
    int           sel;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] pt;
    logic [43:0]  tr;
    int           lat, n, bad_hold, seen;

    vecs[0] = '{0, C1Key, C1Ct, C1Pt, 37};
    vecs[1] = '{1, C1Key, C1Ct, C1Pt, 19};
    vecs[2] = '{0, BKey, BCt, BPt, 37};
    vecs[3] = '{1, BKey, BCt, BPt, 19};
    vecs[4] = '{0, 128'h0, ZCt, 128'h0, 37};
    vecs[5] = '{1, 128'h0, ZCt, 128'h0, 19};

    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    idat  = '0;
`ifdef AES_DEC_ABORT_EN
    ab    = '0;
`endif
    set_key(C1Key);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state on both instances
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_ov", s), 128'(ov[s]), 128'd0);
      chk($sformatf("rst%0d_busy", s), 128'(bsy[s]), 128'd0);
      chk($sformatf("rst%0d_ir", s), 128'(ir[s]), 128'd1);
      chk($sformatf("rst%0d_data", s), (s == 1) ? od1 : od0, 128'd0);
      chk($sformatf("rst%0d_rkidx", s), 128'((s == 1) ? rk1 : rk0), 128'd10);
    end

    // Table-driven known-answer decryptions
    for (int i = 0; i < 6; i++) begin
      set_key(vecs[i].key);
      run_block(vecs[i].sel, vecs[i].ct, pt, lat, tr, n);
      chk($sformatf("vec%0d_pt", i), pt, vecs[i].pt);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].lat));
      chk($sformatf("vec%0d_rktrace", i), 128'(tr), 128'(RkTrace));
      chk($sformatf("vec%0d_rklen", i), 128'(n), 128'd11);
      finish_block(vecs[i].sel, $sformatf("vec%0d", i));
    end

    // Backpressure in DONE, ignored InValid, then back-to-back accept
    set_key(C1Key);
    run_block(0, C1Ct, pt, lat, tr, n);
    chk("bp_first_pt", pt, C1Pt);
    idat = ~C1Ct;
    iv[0] = 1'b1;
    bad_hold = 0;
    for (int i = 0; i < 6; i++) begin
      wait_edge();
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || od0 !== C1Pt) bad_hold++;
    end
    chk("bp_hold_cycles_bad", 128'(bad_hold), 128'd0);
    ordy[0] = 1'b1;
    wait_edge();
    ordy[0] = 1'b0;
    idat = C1Ct;
    chk("b2b_idle_busy", 128'(bsy[0]), 128'd0);
    chk("b2b_idle_ir", 128'(ir[0]), 128'd1);
    chk("b2b_idle_ov", 128'(ov[0]), 128'd0);
    wait_edge();
    iv[0] = 1'b0;
    chk("b2b_accept_busy", 128'(bsy[0]), 128'd1);
    chk("b2b_accept_ir", 128'(ir[0]), 128'd0);
    wait_out(0, lat, tr, n);
    chk("b2b_second_pt", od0, C1Pt);
    chk("b2b_second_lat", 128'(lat), 128'd37);
    finish_block(0, "b2b");

    // Synchronous reset while in MIX at round 5
    idat = C1Ct;
    iv[0] = 1'b1;
    wait_edge();
    iv[0] = 1'b0;
    n = 0;
    while (rk0 != 4'd5 && n < 100) begin
      wait_edge();
      n++;
    end
    wait_edge();
    rst_n = 1'b0;
    wait_edge();
    rst_n = 1'b1;
    chk("midrst_busy", 128'(bsy[0]), 128'd0);
    chk("midrst_ov", 128'(ov[0]), 128'd0);
    chk("midrst_state", bus3.StateOut, 128'd0);
    chk("midrst_ir", 128'(ir[0]), 128'd1);
    chk("midrst_rkidx", 128'(rk0), 128'd10);
    run_block(0, C1Ct, pt, lat, tr, n);
    chk("midrst_fresh_pt", pt, C1Pt);
    chk("midrst_fresh_lat", 128'(lat), 128'd37);
    finish_block(0, "midrst");

`ifdef AES_DEC_ABORT_EN
    // Abort in MIX: idle next cycle and no output ever appears
    idat = C1Ct;
    iv[0] = 1'b1;
    wait_edge();
    iv[0] = 1'b0;
    repeat (3) wait_edge();
    ab[0] = 1'b1;
    wait_edge();
    ab[0] = 1'b0;
    chk("abort_mix_busy", 128'(bsy[0]), 128'd0);
    chk("abort_mix_ir", 128'(ir[0]), 128'd1);
    seen = 0;
    repeat (45) begin
      wait_edge();
      if (ov[0] !== 1'b0) seen++;
    end
    chk("abort_mix_no_ov", 128'(seen), 128'd0);
    // Abort in DONE
    run_block(0, C1Ct, pt, lat, tr, n);
    chk("abort_done_pt", pt, C1Pt);
    ab[0] = 1'b1;
    wait_edge();
    ab[0] = 1'b0;
    chk("abort_done_ov", 128'(ov[0]), 128'd0);
    chk("abort_done_ir", 128'(ir[0]), 128'd1);
    // Abort in IDLE does not block an accept
    ab[0] = 1'b1;
    iv[0] = 1'b1;
    wait_edge();
    ab[0] = 1'b0;
    iv[0] = 1'b0;
    chk("abort_idle_accept", 128'(bsy[0]), 128'd1);
    // Reset wins over Abort
    ab[0] = 1'b1;
    rst_n = 1'b0;
    wait_edge();
    ab[0] = 1'b0;
    rst_n = 1'b1;
    chk("abort_rst_state", bus3.StateOut, 128'd0);
    chk("abort_rst_busy", 128'(bsy[0]), 128'd0);
    chk("abort_rst_rkidx", 128'(rk0), 128'd10);
`endif

    chk("rkidx_range", 128'(oob), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
